// File: rtl/serial_to_parallel_rx_pkg.sv
// serial_pkg: shared definitions for the single-wire serial link
// (transmitter and receiver sides).
//   default_width : default number of bits per word
//   cnt_width()   : bit-counter width needed for a given word width
//   bit_cnt_t     : bit-counter type for the default word width
package serial_pkg;

  localparam int default_width = 8;

  // A counter that runs 0..w-1 needs $clog2(w) bits; never fewer than one.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  typedef logic [cnt_width(default_width)-1:0] bit_cnt_t;

endpackage

// File: rtl/serial_to_parallel_rx_if.sv
// serial_to_parallel_rx_if: bundle of the receiver's serial input, parallel
// output slot and status signals.
//   serial_valid/serial_data : one serial bit per valid cycle, LSB first
//   parallel_valid/data      : completed word held in the output slot
//   parallel_ready           : consumer accepts the word this cycle
//   busy, overflow           : partial word in progress / sticky word drop
// Modports: master = link driver and consumer, slave = receiver.
//
// Handshake: a word transfers on every posedge where parallel_valid and
// parallel_ready are both 1. While parallel_valid=1 and parallel_ready=0 the
// word in parallel_data is held stable. parallel_ready has no meaning while
// parallel_valid=0. serial_valid has no back-pressure: a bit is taken on
// every posedge where serial_valid=1.
interface serial_to_parallel_rx_if #(
  parameter int width = serial_pkg::default_width
);

  logic             serial_valid;
  logic             serial_data;
  logic             parallel_valid;
  logic [width-1:0] parallel_data;
  logic             parallel_ready;
  logic             busy;
  logic             overflow;

  modport master (
    output serial_valid, serial_data, parallel_ready,
    input  parallel_valid, parallel_data, busy, overflow
  );

  modport slave (
    input  serial_valid, serial_data, parallel_ready,
    output parallel_valid, parallel_data, busy, overflow
  );

endinterface

// File: rtl/serial_to_parallel_rx_valid_ready_slot.sv
// valid_ready_slot: one-entry output holding register.
//   clk, rst  : clock, synchronous active-high reset
//   load      : a new word is offered this cycle
//   load_data : the offered word
//   ready     : consumer accepts the held word this cycle
//   valid     : slot holds a word
//   data      : held word (unchanged while not reloaded)
//   overflow  : sticky, set when an offered word is dropped on a full slot
module valid_ready_slot #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [width-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [width-1:0] data,
  output logic             overflow
);

  // Draining and loading on the same edge keeps the slot full with the new word.
  logic slot_free;
  assign slot_free = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      data     <= '0;
      overflow <= 1'b0;
    end else if (load) begin
      if (slot_free) begin
        data  <= load_data;
        valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx: receiver end of the single-wire serial link.
// Collects `width` valid-qualified bits, LSB first, into one word and hands
// it to a one-entry valid/ready output slot (latency 1 from the last bit).
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset, priority over everything
//   bus  : serial_to_parallel_rx_if.slave (serial in, parallel out, status)
// Parameters: width (>= 2) bits per word, max_gap (>= 1) idle cycles
// tolerated mid-word when the gap timeout is built in.
// Build option: define S2P_GAP_TIMEOUT_EN to discard a partial word after
// max_gap consecutive idle cycles; otherwise partial words wait indefinitely.
module serial_to_parallel_rx
  import serial_pkg::*;
#(
  parameter int width   = default_width,
  parameter int max_gap = 4
) (
  input logic                    clk,
  input logic                    rst,
  serial_to_parallel_rx_if.slave bus
);

  localparam int cw = cnt_width(width);
  localparam logic [cw-1:0] last_idx = cw'(width - 1);

  if (width < 2 || max_gap < 1) begin : g_param_check
    $error("serial_to_parallel_rx: width must be >= 2 and max_gap >= 1");
  end

  logic [cw-1:0]    cnt;
  logic [width-1:0] shreg;
  logic [width-1:0] word;
  logic             complete;
  logic             gap_expire;

  // The incoming bit lands in the MSB; after width shifts the first bit is the LSB.
  assign word     = {bus.serial_data, shreg[width-1:1]};
  assign complete = bus.serial_valid && (cnt == last_idx);
  assign bus.busy = (cnt != '0);

`ifdef S2P_GAP_TIMEOUT_EN
  localparam int gw = $clog2(max_gap + 1);
  logic [gw-1:0] gap;

  // Fires on the idle edge that would bring the gap count up to max_gap.
  assign gap_expire = bus.busy && !bus.serial_valid && (gap == gw'(max_gap - 1));

  always_ff @(posedge clk) begin
    if (rst || !bus.busy || bus.serial_valid || gap_expire) begin
      gap <= '0;
    end else begin
      gap <= gap + gw'(1);
    end
  end
`else
  assign gap_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (bus.serial_valid) begin
      shreg <= word;
      cnt   <= complete ? '0 : cnt + cw'(1);
    end else if (gap_expire) begin
      cnt <= '0;
    end
  end

  valid_ready_slot #(
    .width(width)
  ) u_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (complete),
    .load_data(word),
    .ready    (bus.parallel_ready),
    .valid    (bus.parallel_valid),
    .data     (bus.parallel_data),
    .overflow (bus.overflow)
  );

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb_serial_to_parallel_rx: bench for serial_to_parallel_rx (width=8, max_gap=4).
// A queue-of-bits reference model predicts the slot, busy and overflow every
// cycle; directed scenarios add literal expectations and an in-order
// scoreboard; a randomized phase follows. Honours S2P_GAP_TIMEOUT_EN.
module tb_serial_to_parallel_rx;

  localparam int W  = 8;
  localparam int MG = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_to_parallel_rx_if #(.width(W)) bus ();

  serial_to_parallel_rx #(
    .width  (W),
    .max_gap(MG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  bit sb_on    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_bits[$];
  logic [W-1:0] m_data  = '0;
  logic         m_valid = 1'b0;
  logic         m_ovf   = 1'b0;
  int           m_idle  = 0;
  logic [W-1:0] m_word;
  bit           m_done;

  always @(posedge clk) begin
    if (rst) begin
      m_bits.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_idle  = 0;
    end else begin
      m_done = 1'b0;
      if (bus.serial_valid) begin
        m_bits.push_back(int'(bus.serial_data));
        m_idle = 0;
        if (m_bits.size() == W) begin
          for (int i = 0; i < W; i++) m_word[i] = m_bits[i][0];
          m_bits.delete();
          m_done = 1'b1;
        end
      end
`ifdef S2P_GAP_TIMEOUT_EN
      else if (m_bits.size() > 0) begin
        m_idle++;
        if (m_idle == MG) begin
          m_bits.delete();
          m_idle = 0;
        end
      end else begin
        m_idle = 0;
      end
`endif
      if (m_done) begin
        if (!m_valid || bus.parallel_ready) begin
          m_data  = m_word;
          m_valid = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_valid && bus.parallel_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_valid", 32'(bus.parallel_valid), 32'(m_valid));
      check("m_data", 32'(bus.parallel_data), 32'(m_data));
      check("m_busy", 32'(bus.busy), 32'(m_bits.size() != 0));
      check("m_overflow", 32'(bus.overflow), 32'(m_ovf));
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (sb_on && bus.parallel_valid && bus.parallel_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 32'(bus.parallel_data), 32'hFFFF_FFFF);
      end else begin
        check("sb_word", 32'(bus.parallel_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.serial_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bus.serial_valid = 1'b1;
    bus.serial_data  = b;
    tick();
    bus.serial_valid = 1'b0;
  endtask

  // Sends nbits of w LSB first; gap>0 inserts 1..gap idle cycles between bits.
  task automatic send_word(input logic [W-1:0] w, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) begin
      send_bit(w[i]);
      if (gap > 0 && i < nbits - 1) repeat ($urandom_range(1, gap)) tick();
    end
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] t1_word;

  initial begin
    bus.serial_valid   = 1'b0;
    bus.serial_data    = 1'b0;
    bus.parallel_ready = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    check("rst_valid", 32'(bus.parallel_valid), 32'd0);
    check("rst_data", 32'(bus.parallel_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    chk_en = 1'b1;

    // 1: bits 1,0,1,1,0,0,1,0 -> 8'h4D, one-cycle valid pulse
    t1_word = 8'b0100_1101;
    send_bit(t1_word[0]);
    check("t1_busy_bit1", 32'(bus.busy), 32'd1);
    for (int i = 1; i < W; i++) send_bit(t1_word[i]);
    check("t1_valid", 32'(bus.parallel_valid), 32'd1);
    check("t1_data", 32'(bus.parallel_data), 32'h4D);
    check("t1_busy_done", 32'(bus.busy), 32'd0);
    tick();
    check("t1_valid_pulse", 32'(bus.parallel_valid), 32'd0);

    // 2: back-to-back A5, 3C through the scoreboard
    do_reset();
    sb_on = 1'b1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_word(8'hA5, W, 0);
    send_word(8'h3C, W, 0);
    repeat (2) tick();
    sb_on = 1'b0;
    check("t2_sb_drained", 32'(exp_q.size()), 32'd0);
    check("t2_overflow", 32'(bus.overflow), 32'd0);

    // 3: full slot drops 22, overflow sticks
    do_reset();
    bus.parallel_ready = 1'b0;
    send_word(8'h11, W, 0);
    send_word(8'h22, W, 0);
    check("t3_data_held", 32'(bus.parallel_data), 32'h11);
    check("t3_overflow", 32'(bus.overflow), 32'd1);
    bus.parallel_ready = 1'b1;
    tick();
    check("t3_valid_drop", 32'(bus.parallel_valid), 32'd0);
    check("t3_overflow_sticky", 32'(bus.overflow), 32'd1);

    // 4: drain and load on the same edge
    do_reset();
    bus.parallel_ready = 1'b0;
    send_word(8'h11, W, 0);
    send_word(8'h22, W - 1, 0);
    bus.parallel_ready = 1'b1;
    send_bit(1'b0);
    check("t4_data", 32'(bus.parallel_data), 32'h22);
    check("t4_valid", 32'(bus.parallel_valid), 32'd1);
    check("t4_overflow", 32'(bus.overflow), 32'd0);

    // 5: gapped F0, then reset mid-word and a fresh 81
    do_reset();
    send_word(8'hF0, W, 3);
    check("t5_gapped", 32'(bus.parallel_data), 32'hF0);
    send_word(8'h07, 3, 0);
    do_reset();
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    send_word(8'h81, W, 0);
    check("t5_after_rst", 32'(bus.parallel_data), 32'h81);

    // 6: 3 bits, 4 idle cycles, then 81 with the slot blocked
    do_reset();
    bus.parallel_ready = 1'b0;
    send_word(8'h07, 3, 0);
    repeat (MG) tick();
    send_word(8'h81, W, 0);
`ifdef S2P_GAP_TIMEOUT_EN
    check("t6_word", 32'(bus.parallel_data), 32'h81);
    check("t6_busy", 32'(bus.busy), 32'd0);
`else
    check("t6_word", 32'(bus.parallel_data), 32'h0F);
    check("t6_busy", 32'(bus.busy), 32'd1);
`endif
    check("t6_overflow", 32'(bus.overflow), 32'd0);

    // Randomized phase: varying bit density, random ready, rare resets
    do_reset();
    for (int seg = 0; seg < 20; seg++) begin
      int density;
      density = $urandom_range(1, 8);
      for (int c = 0; c < 150; c++) begin
        bus.serial_valid   = ($urandom_range(0, 7) < density);
        bus.serial_data    = 1'($urandom_range(0, 1));
        bus.parallel_ready = ($urandom_range(0, 3) != 0);
        rst                = ($urandom_range(0, 399) == 0);
        tick();
      end
    end
    rst = 1'b0;
    bus.serial_valid = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
